// File: rtl/regfile_write_arbiter.sv
// Shares one register-file write port among NREQ writeback sources.
// Each source owns a one-entry buffer; a round-robin arbiter drains one buffer per cycle into a registered write stage.
module regfile_write_arbiter #(
  parameter int NREQ  = 3,
  parameter int CNT_W = 16
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [5*NREQ-1:0] req_reg,
  input  logic [32*NREQ-1:0] req_data,
  output logic              ctrl_writeEnable,
  output logic [4:0]        ctrl_writeReg,
  output logic [31:0]       data_writeReg,
  output logic [2:0]        grant_id,
  input  logic [4:0]        ctrl_readRegA,
  input  logic [4:0]        ctrl_readRegB,
  output logic              hazard_A,
  output logic              hazard_B,
  output logic [CNT_W-1:0]  contention_count
);

  logic [NREQ-1:0] held;
  logic [4:0]      bufReg  [NREQ];
  logic [31:0]     bufData [NREQ];
  logic [2:0]      rrPtr;

  logic            winValid;
  logic [2:0]      winIdx;
  logic [2:0]      nextPtr;
  logic [NREQ-1:0] grantMask;
  logic [NREQ-1:0] accept;
  logic            contended;

  // Ready comes straight from held state, so a source never sees a combinational path from its own valid.
  assign req_ready = ~held;
  assign accept    = req_valid & ~held;
  assign contended = ($countones(held) >= 2);

  // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    int idx;
    winValid = 1'b0;
    winIdx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rrPtr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!winValid && held[idx]) begin
        winValid = 1'b1;
        winIdx   = 3'(idx);
      end
    end
  end

  always_comb begin
    grantMask = '0;
    if (winValid) grantMask[winIdx] = 1'b1;
    nextPtr = (int'(winIdx) == NREQ - 1) ? 3'd0 : winIdx + 3'd1;
  end

  // A write still in a buffer or in the write stage is visible to readers as a hazard.
  always_comb begin
    hazard_A = ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegA);
    hazard_B = ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegB);
    for (int i = 0; i < NREQ; i++) begin
      if (held[i] && bufReg[i] == ctrl_readRegA) hazard_A = 1'b1;
      if (held[i] && bufReg[i] == ctrl_readRegB) hazard_B = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      held             <= '0;
      rrPtr            <= '0;
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
      grant_id         <= '0;
      contention_count <= '0;
      // NOTE: the buffers are small flop arrays, not RAM, so clearing them on reset costs nothing.
      for (int i = 0; i < NREQ; i++) begin
        bufReg[i]  <= '0;
        bufData[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (accept[i]) begin
          bufReg[i]  <= req_reg[5*i +: 5];
          bufData[i] <= req_data[32*i +: 32];
        end
      end
      // accept and grant never hit the same entry: a granted entry is held, so it is not ready.
      held <= (held & ~grantMask) | accept;

      if (winValid) begin
        ctrl_writeEnable <= 1'b1;
        ctrl_writeReg    <= bufReg[winIdx];
        data_writeReg    <= bufData[winIdx];
        grant_id         <= winIdx;
        rrPtr            <= nextPtr;
      end else begin
        ctrl_writeEnable <= 1'b0;
      end

      if (contended && !(&contention_count))
        contention_count <= contention_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter against a behavioural model of its buffers and arbitration.
// A second instance with a 2-bit counter exercises saturation on the same stimulus.
module tb_regfile_write_arbiter;
  localparam int NREQ = 3;

  logic              clock;
  logic              ctrl_reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [5*NREQ-1:0] req_reg;
  logic [32*NREQ-1:0] req_data;
  logic              ctrl_writeEnable;
  logic [4:0]        ctrl_writeReg;
  logic [31:0]       data_writeReg;
  logic [2:0]        grant_id;
  logic [4:0]        ctrl_readRegA, ctrl_readRegB;
  logic              hazard_A, hazard_B;
  logic [15:0]       contention_count;

  logic [NREQ-1:0]   satReady;
  logic              satWe;
  logic [4:0]        satWReg;
  logic [31:0]       satWData;
  logic [2:0]        satGrant;
  logic              satHazA, satHazB;
  logic [1:0]        satCount;

  regfile_write_arbiter #(.NREQ(NREQ), .CNT_W(16)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_reg(req_reg), .req_data(req_data),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .grant_id(grant_id), .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .hazard_A(hazard_A), .hazard_B(hazard_B), .contention_count(contention_count)
  );

  regfile_write_arbiter #(.NREQ(NREQ), .CNT_W(2)) satDut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .req_valid(req_valid), .req_ready(satReady), .req_reg(req_reg), .req_data(req_data),
    .ctrl_writeEnable(satWe), .ctrl_writeReg(satWReg), .data_writeReg(satWData),
    .grant_id(satGrant), .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .hazard_A(satHazA), .hazard_B(satHazB), .contention_count(satCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: what each source has parked, and what the write port shows.
  bit          mHeld [NREQ];
  logic [4:0]  mReg  [NREQ];
  logic [31:0] mData [NREQ];
  int          mRr;
  bit          mWe;
  logic [4:0]  mWReg;
  logic [31:0] mWData;
  int          mGrant;
  int          mCnt, mCntSat;

  task automatic modelReset();
    for (int i = 0; i < NREQ; i++) begin
      mHeld[i] = 0; mReg[i] = '0; mData[i] = '0;
    end
    mRr = 0; mWe = 0; mWReg = '0; mWData = '0; mGrant = 0; mCnt = 0; mCntSat = 0;
  endtask

  task automatic modelEdge();
    int n, w;
    n = 0; w = -1;
    for (int i = 0; i < NREQ; i++) n += mHeld[i];
    for (int k = 0; k < NREQ; k++)
      if (w < 0 && mHeld[(mRr + k) % NREQ]) w = (mRr + k) % NREQ;
    if (w >= 0) begin
      mWe = 1; mWReg = mReg[w]; mWData = mData[w]; mGrant = w; mRr = (w + 1) % NREQ;
    end else begin
      mWe = 0;
    end
    if (n >= 2) begin
      if (mCnt < 65535) mCnt++;
      if (mCntSat < 3) mCntSat++;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && !mHeld[i]) begin
        mHeld[i] = 1; mReg[i] = req_reg[5*i +: 5]; mData[i] = req_data[32*i +: 32];
      end
    end
    if (w >= 0) mHeld[w] = 0;
  endtask

  function automatic bit modelHazard(input logic [4:0] r);
    bit h;
    h = mWe && (mWReg == r);
    for (int i = 0; i < NREQ; i++) if (mHeld[i] && mReg[i] == r) h = 1;
    return h;
  endfunction

  task automatic checkAll();
    logic [NREQ-1:0] expReady;
    for (int i = 0; i < NREQ; i++) expReady[i] = !mHeld[i];
    check("ready", req_ready, expReady);
    check("we", ctrl_writeEnable, mWe);
    check("wreg", ctrl_writeReg, mWReg);
    check("wdata", data_writeReg, mWData);
    check("grant", grant_id, mGrant);
    check("hazA", hazard_A, modelHazard(ctrl_readRegA));
    check("hazB", hazard_B, modelHazard(ctrl_readRegB));
    check("count", contention_count, mCnt);
    check("satCount", satCount, mCntSat);
  endtask

  // Inputs are driven at the falling edge; the model advances on the rising edge; outputs checked at the next fall.
  task automatic stepCycle();
    @(posedge clock);
    if (ctrl_reset) modelEdge();
    @(negedge clock);
    checkAll();
  endtask

  task automatic resetDut();
    ctrl_reset = 1'b0;
    #1;
    modelReset();
    checkAll();
    check("rst_ready", req_ready, 3'b111);
    check("rst_we", ctrl_writeEnable, 0);
    @(negedge clock);
    ctrl_reset = 1'b1;
  endtask

  task automatic setReq(input int i, input logic [4:0] r, input logic [31:0] d);
    req_reg[5*i +: 5]   = r;
    req_data[32*i +: 32] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    ctrl_reset = 1'b0;
    req_valid = '0; req_reg = '0; req_data = '0;
    ctrl_readRegA = 5'd0; ctrl_readRegB = 5'd0;
    modelReset();
    #1;
    checkAll();
    @(negedge clock);
    ctrl_reset = 1'b1;

    // Single request: visible on the write port one edge after acceptance, gone one edge later.
    setReq(0, 5'd5, 32'hDEADBEEF);
    req_valid = 3'b001;
    stepCycle();
    req_valid = '0;
    stepCycle();
    check("single_we", ctrl_writeEnable, 1);
    check("single_reg", ctrl_writeReg, 5);
    check("single_data", data_writeReg, 32'hDEADBEEF);
    check("single_grant", grant_id, 0);
    stepCycle();
    check("single_we_drop", ctrl_writeEnable, 0);

    // Simultaneous requests from a fresh pointer drain in index order.
    resetDut();
    setReq(0, 5'd1, 32'h11); setReq(1, 5'd2, 32'h22); setReq(2, 5'd3, 32'h33);
    req_valid = 3'b111;
    stepCycle();
    req_valid = '0;
    for (int k = 1; k <= 3; k++) begin
      stepCycle();
      check("simul_we", ctrl_writeEnable, 1);
      check("simul_reg", ctrl_writeReg, k);
    end
    check("simul_count", contention_count, 2);

    // All sources kept busy: grants rotate 0,1,2,0,1,2.
    setReq(0, 5'd10, 32'hA0); setReq(1, 5'd11, 32'hA1); setReq(2, 5'd12, 32'hA2);
    req_valid = 3'b111;
    stepCycle();
    for (int k = 0; k < 6; k++) begin
      stepCycle();
      check("rr_grant", grant_id, k % 3);
      check("rr_we", ctrl_writeEnable, 1);
    end
    check("sat_stuck", satCount, 3);
    req_valid = '0;
    repeat (4) stepCycle();

    // Hazard tracked from buffer through write stage until the write retires.
    resetDut();
    ctrl_readRegA = 5'd7; ctrl_readRegB = 5'd8;
    setReq(1, 5'd7, 32'h77);
    req_valid = 3'b010;
    stepCycle();
    req_valid = '0;
    check("haz_buf_A", hazard_A, 1);
    check("haz_buf_B", hazard_B, 0);
    stepCycle();
    check("haz_stage_A", hazard_A, 1);
    check("haz_stage_B", hazard_B, 0);
    stepCycle();
    check("haz_retired_A", hazard_A, 0);

    // Random traffic, with a reset dropped into the middle of a burst.
    for (int c = 0; c < 400; c++) begin
      req_valid = NREQ'($urandom_range(0, 7));
      for (int i = 0; i < NREQ; i++) setReq(i, 5'($urandom_range(0, 7)), $urandom);
      ctrl_readRegA = 5'($urandom_range(0, 7));
      ctrl_readRegB = 5'($urandom_range(0, 7));
      if (c == 200) begin
        req_valid = 3'b111;
        stepCycle();
        resetDut();
        req_valid = '0;
        stepCycle();
        check("rst_nowrite", ctrl_writeEnable, 0);
      end else begin
        stepCycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
